regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data width of each register in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning number of architectural registers; legal range is 2 to 2**AW.
REQ-003 The block SHALL have parameter AW, default 5, meaning register address width in bits.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports A1 and A2, input, AW bits each: read addresses for ports 1 and 2.
REQ-007 The block SHALL have port A3, input, AW bits: write address.
REQ-008 The block SHALL have port WD3, input, XLEN bits: write data.
REQ-009 The block SHALL have port WE3, input, 1 bit: write enable.
REQ-010 The block SHALL have ports RD1 and RD2, output, XLEN bits each: read data for ports 1 and 2.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high while the clear sequence runs; the core stalls on it.

Function
REQ-012 The block SHALL provide a two-state FSM, CLEAR and IDLE, plus a clear counter CNT of AW bits.
REQ-013 In CLEAR, on each rising edge the block SHALL write zero to REG[CNT] and then increment CNT.
REQ-014 The FSM SHALL move CLEAR->IDLE on the edge that clears REG[NREGS-1]; IDLE SHALL persist until the next RST.
REQ-015 After RST deasserts, BUSY SHALL stay high for exactly NREGS-1 rising edges and SHALL go low after the edge that clears REG[NREGS-1].
REQ-016 Writes presented while BUSY=1 SHALL be discarded, not queued.
REQ-017 RD1 and RD2 SHALL read 0 while BUSY=1.
REQ-018 In IDLE, a write SHALL occur on a rising edge when WE3=1, A3!=0 and A3<NREGS; otherwise the edge SHALL leave storage unchanged.
REQ-019 Register 0 SHALL always read 0 and SHALL never be written.
REQ-020 Reads SHALL be combinational, with zero latency, on both ports.
REQ-021 A read address >= NREGS SHALL return 0.
REQ-022 A1 and A2 MAY be equal and SHALL then both return the same value.
REQ-023 A write becomes visible after the rising edge on which it occurs; same-cycle behaviour is defined by REQ-029/REQ-030.

Reset
REQ-024 Asserting RST SHALL immediately set FSM=CLEAR, CNT=1 and BUSY=1, independent of CLK.
REQ-025 RST asserted mid-clear SHALL restart the sequence at CNT=1; a partially cleared array is not retained as valid.
REQ-026 RST asserted while a write is pending SHALL discard that write.
REQ-027 While RST is held, CNT SHALL stay at 1 and no array writes SHALL occur.
REQ-028 Output reset values SHALL be BUSY=1, RD1=0 and RD2=0.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, a read port SHALL return WD3 combinationally whenever WE3=1, BUSY=0, A3!=0, A3<NREGS and A3 equals that port's address (write-first forwarding).
REQ-030 With REGFILE_BYPASS_EN undefined, a read port SHALL return the stored value before the write (read-first), and no forwarding logic SHALL exist.

Verification
REQ-031 Reset scenario: pulse RST mid-cycle with NREGS=32 -> BUSY=1 at once, BUSY=0 after exactly 31 edges post-deassert, and all 32 registers read 0.
REQ-032 Write/read scenario: after clear, write 0xDEADBEEF to x5, then set A1=5, A2=5 -> RD1=RD2=0xDEADBEEF on the next cycle.
REQ-033 x0 scenario: write 0xFFFFFFFF to A3=0 -> RD1 with A1=0 reads 0.
REQ-034 Bypass scenario: x7 holds 0x11; in the same cycle WE3=1, A3=7, WD3=0x22, A1=7 -> RD1=0x22 with REGFILE_BYPASS_EN defined, RD1=0x11 without it; x7 reads 0x22 after the edge in both builds.
REQ-035 Clear-abort scenario: write during BUSY (A3=3, WD3=0x55), then assert RST at clear edge 10 -> x3 reads 0 and BUSY lasts 31 further edges.
REQ-036 Parameter scenario: NREGS=16, XLEN=64, AW=5; A3=20 write and A1=20 read -> no write occurs, RD1=0, and the clear takes 15 edges.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: two-read/one-write register file with a self-clearing reset sweep.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding to the read ports.
module regfile_param #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            WE3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [AW-1:0] CNT_FIRST = AW'(1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_EXT = (AW + 1)'(NREGS);

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic            busy;
  logic            a3_legal;
  logic            wr_ok;
  logic [XLEN-1:0] mem [1:NREGS-1];

  assign busy     = (state == ST_CLEAR);
  assign BUSY     = busy;
  assign a3_legal = (A3 != '0) && ({1'b0, A3} < NREGS_EXT);
  assign wr_ok    = WE3 && !busy && a3_legal;

  // Clear sweep: walk cnt from 1 to NREGS-1, then park in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_CLEAR;
      cnt   <= CNT_FIRST;
    end else begin
      unique case (1'b1)
        (state == ST_CLEAR): begin
          cnt <= cnt + AW'(1);
          if (cnt == CNT_LAST)
            state <= ST_IDLE;
        end
        (state == ST_IDLE): begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= CNT_FIRST;
        end
      endcase
    end
  end

  // Storage: sweep zeroes during CLEAR, normal writes only in IDLE;
  // nothing is written while reset is held. x0 has no storage.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 1; i < NREGS; i++) begin
        if (busy && (cnt == AW'(i)))
          mem[i] <= '0;
        else if (wr_ok && (A3 == AW'(i)))
          mem[i] <= WD3;
      end
    end
  end

  // Read port 1: zero when busy, for x0 and for out-of-range addresses.
  always_comb begin
    RD1 = '0;
    if (!busy) begin
      for (int i = 1; i < NREGS; i++) begin
        if (A1 == AW'(i))
          RD1 = mem[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (A3 == A1))
        RD1 = WD3;
`endif
    end
  end

  // Read port 2: same decode as port 1.
  always_comb begin
    RD2 = '0;
    if (!busy) begin
      for (int i = 1; i < NREGS; i++) begin
        if (A2 == AW'(i))
          RD2 = mem[i];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (A3 == A2))
        RD2 = WD3;
`endif
    end
  end

endmodule
